// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and constants for the instruction/data memory
// arbiter.
//   state_t : arbiter state (IDLE may grant, WAIT has a read outstanding)
//   owner_t : which requester owns the outstanding read
//   CNT_W   : latency down-counter width, sized for the largest MEM_LAT (4)
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  localparam int CNT_W = $clog2(4) + 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- requester-side handshake bundle of mem_arbiter.
//   fetch port : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
//   data port  : d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata out
// modport master is the pipeline side and modport slave is the arbiter side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr -- saturating count of consecutive fetch arbitrations lost
// to the data port. Used only when MEM_ARB_STARVE_GUARD_EN is defined.
//   clk, rst    : clock, asynchronous active-low reset
//   inc         : fetch requested but data was granted this cycle
//   clr         : fetch granted this cycle
//   force_fetch : count has reached STARVE_MAX; fetch must win next
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic force_fetch
);

  localparam int W = $clog2(STARVE_MAX + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != W'(STARVE_MAX))) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign force_fetch = (cnt_q == W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port memory between the fetch port and
// the data port of the pipeline, with at most one read outstanding.
//   clk, rst  : clock, asynchronous active-low reset
//   bus       : mem_arbiter_if.slave, both requester handshakes
//   mem_en/mem_we/mem_addr/mem_wdata : memory command (all 0 when idle)
//   mem_rdata : memory read data, valid MEM_LAT cycles after the command
//   busy      : a read is outstanding
// Optional macro MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard;
// without it the data port always wins a simultaneous request.
//
// state | meaning
// IDLE  | may grant; writes complete here in one cycle
// WAIT  | read outstanding; counter runs down from MEM_LAT
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be 1..4");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_gnt, d_gnt, cap_if, cap_d, force_fetch;
  logic             if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk         (clk),
    .rst         (rst),
    .inc         (bus.if_req & d_gnt),
    .clr         (if_gnt),
    .force_fetch (force_fetch)
  );
`else
  assign force_fetch = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    cap_if  = 1'b0;
    cap_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Grants are combinational, so they are also held off while reset
        // is asserted to keep every output at 0 during reset.
        if (rst) begin
          if (bus.d_req && !(force_fetch && bus.if_req)) begin
            d_gnt = 1'b1;
          end else if (bus.if_req) begin
            if_gnt = 1'b1;
          end
          if (if_gnt || (d_gnt && !bus.d_we)) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(MEM_LAT);
            owner_d = if_gnt ? OWN_IF : OWN_D;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cap_if  = (owner_q == OWN_IF);
          cap_d   = (owner_q == OWN_D);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      if_rvalid_q <= cap_if;
      d_rvalid_q  <= cap_d;
      if (cap_if) if_rdata_q <= mem_rdata;
      if (cap_d)  d_rdata_q  <= mem_rdata;
    end
  end

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & bus.d_we;
  assign mem_addr  = d_gnt ? bus.d_addr : (if_gnt ? bus.if_addr : '0);
  assign mem_wdata = d_gnt ? bus.d_wdata : '0;
  assign busy      = (state_q == WAIT);

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- randomized bench for mem_arbiter with a cycle-level
// reference model and a read-response scoreboard.
// Honours MEM_ARB_STARVE_GUARD_EN in its model when the macro is defined.
module tb_mem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  typedef struct {
    bit is_d;
    int due;
  } exp_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [31:0] rd_hist [0:8191];
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;

  // Requester intentions, held until granted.
  bit          if_pend = 0, d_pend = 0, d_w = 0;
  logic [31:0] if_a = '0, d_a = '0, d_wd = '0;
  // Memory is busy with a read through this cycle number.
  int          busy_until = -1;
`ifdef MEM_ARB_STARVE_GUARD_EN
  int          starve = 0;
`endif

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_comb();
    bit idle, force_f, eg_d, eg_if;
    idle    = rst && (cyc > busy_until);
    force_f = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    force_f = (starve >= STARVE_MAX);
`endif
    eg_d  = idle && d_pend && !(force_f && if_pend);
    eg_if = idle && if_pend && !eg_d;

    chk("if_gnt",    bus.if_gnt, eg_if);
    chk("d_gnt",     bus.d_gnt, eg_d);
    chk("mem_en",    mem_en, eg_d | eg_if);
    chk("mem_we",    mem_we, eg_d && d_w);
    chk("mem_addr",  mem_addr, eg_d ? d_a : (eg_if ? if_a : 32'h0));
    chk("mem_wdata", mem_wdata, eg_d ? d_wd : 32'h0);
    chk("busy",      busy, rst && (cyc <= busy_until));

    if (eg_if || (eg_d && !d_w)) begin
      busy_until = cyc + MEM_LAT;
      sb.push_back('{is_d: eg_d, due: cyc + MEM_LAT + 1});
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    if (eg_if) starve = 0;
    else if (eg_d && if_pend && starve < STARVE_MAX) starve++;
`endif
    if (eg_if) if_pend = 0;
    if (eg_d)  d_pend  = 0;
  endtask

  task automatic step(int p_if, int p_d, int p_we, bit rst_v);
    @(posedge clk);
    cyc++;
    #1;
    rst = rst_v;
    if (!rst_v) begin
      sb.delete();
      busy_until   = -1;
      exp_if_rdata = '0;
      exp_d_rdata  = '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve = 0;
`endif
    end
    if (!if_pend && $urandom_range(99) < p_if) begin
      if_pend = 1;
      if_a    = $urandom & 32'hFFFF_FFFC;
    end
    if (!d_pend && $urandom_range(99) < p_d) begin
      d_pend = 1;
      d_w    = ($urandom_range(99) < p_we);
      d_a    = $urandom & 32'hFFFF_FFFC;
      d_wd   = $urandom;
    end
    bus.if_req  = if_pend;
    bus.if_addr = if_a;
    bus.d_req   = d_pend;
    bus.d_we    = d_w;
    bus.d_addr  = d_a;
    bus.d_wdata = d_wd;
    mem_rdata   = $urandom;
    rd_hist[cyc] = mem_rdata;
    #1;
    check_comb();
  endtask

  // Response monitor: pops an expectation whenever the DUT raises rvalid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.if_rvalid || bus.d_rvalid) begin
        if (sb.size() == 0) begin
          chk("spurious_rvalid", {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("rvalid_cycle", cyc, e.due);
          chk("rvalid_port", {30'h0, bus.if_rvalid, bus.d_rvalid},
              e.is_d ? 32'h1 : 32'h2);
          if (e.is_d) exp_d_rdata  = rd_hist[e.due-1];
          else        exp_if_rdata = rd_hist[e.due-1];
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rvalid_missing", {30'h0, bus.if_rvalid, bus.d_rvalid},
            e.is_d ? 32'h1 : 32'h2);
      end
      chk("if_rdata", bus.if_rdata, exp_if_rdata);
      chk("d_rdata",  bus.d_rdata, exp_d_rdata);
    end
  end

  initial begin
    bit got_read;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; mem_rdata = '0;

    // Reset with both requests pending: nothing may be granted.
    for (int i = 0; i < 3; i++) step(100, 100, 0, 0);
    // Fetch-only traffic.
    for (int i = 0; i < 40; i++) step(60, 0, 0, 1);
    // Mixed random traffic.
    for (int i = 0; i < 1500; i++) step(50, 50, 50, 1);
    // Continuous writes against a waiting fetch.
    for (int i = 0; i < 40; i++) step(100, 100, 100, 1);
    // Continuous reads from both ports.
    for (int i = 0; i < 200; i++) step(100, 100, 0, 1);

    // Reset while a read is outstanding.
    got_read = 0;
    for (int i = 0; i < 50 && !got_read; i++) begin
      step(100, 100, 0, 1);
      got_read = (busy_until > cyc);
    end
    chk("reset_setup_read", {31'h0, got_read}, 32'h1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(40, 40, 50, 1);

    // Drain.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    @(negedge clk);
    chk("scoreboard_drain", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one single-port unified memory between the fetch stage (instruction port) and the access stage (data port) of the rv32 pipeline.
- Sits between those two pipeline stages and the memory macro.
- Uses a req/gnt handshake per requester and allows one outstanding read.
- Data-port priority is the default; an optional starvation guard bounds fetch wait.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles. Legal range 1..4.
- STARVE_MAX, 4, number of consecutive lost fetch arbitrations before fetch is forced to win. Used only with the guard.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset. Asynchronous assert, active-low.
- if_req  in  1  fetch read request. Held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  registered fetch read data.
- d_req  in  1  data request. Held with d_we, d_addr and d_wdata until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; d_rdata valid. Reads only.
- d_rdata  out  DATA_W  registered data read result.
- mem_en  out  1  memory command strobe. Equals if_gnt | d_gnt.
- mem_we  out  1  write strobe. Qualified by mem_en.
- mem_addr  out  ADDR_W  command address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data. Valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  a read is outstanding (state != IDLE).

## Operation
- States:
  - IDLE: may grant.
  - WAIT: read outstanding. A down-counter is loaded with MEM_LAT on a read grant.
- Arbitration happens in IDLE only. Grants are combinational from the request inputs and state.
  - Both requesting: data wins, unless forced-fetch (see Configuration).
  - Only one requesting: that requester wins.
  - At most one gnt per cycle.
- Command outputs on a grant cycle:
  - mem_en=1; mem_addr/mem_we/mem_wdata come from the winner.
  - A fetch grant sets mem_we=0.
  - When mem_en=0: mem_addr, mem_we and mem_wdata are driven 0.
- Write grant: completes in the grant cycle. State stays IDLE, no rvalid, another grant is allowed next cycle.
- Read grant: the owner (IF/D) is recorded, then IDLE→WAIT.
- In WAIT:
  - Both gnts and mem_en are 0; requests are ignored and stay pending.
  - The counter decrements each cycle. At count 1, mem_rdata is captured into the owner's rdata register, the owner's rvalid is set for the next cycle, and the state returns to IDLE.
- Rvalid cycle: the block is in IDLE and may grant a new request in the same cycle as the rvalid pulse.
- The non-owner's rdata register holds its previous value.
- A request deasserted before its gnt is dropped silently. Requesters must not do this for data writes.
- Reset, asynchronous:
  - State=IDLE, counter=0, owner=IF, starve count=0.
  - All outputs 0, including both rdata registers.
  - Reset during WAIT discards the read; no rvalid is produced after release.

## Timing
- Grant latency: 0 cycles from a request in IDLE.
- Read with grant in cycle T:
  - mem_rdata is sampled at the end of cycle T+MEM_LAT.
  - rvalid/rdata are asserted in cycle T+MEM_LAT+1.
  - Example, MEM_LAT=1: gnt in cycle 0, rvalid in cycle 2.
- Peak throughput: 1 read per MEM_LAT+1 cycles; 1 write per cycle.
- busy is high in cycles T+1..T+MEM_LAT.

## Configuration
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined: a fetch-starve counter increments on each IDLE cycle where if_req=1 and d_gnt=1. It clears on if_gnt.
  - At STARVE_MAX, forced-fetch is asserted: the next IDLE cycle with if_req=1 grants fetch even when d_req=1.
  - The counter saturates at STARVE_MAX.
- Undefined: strict data priority; fetch may starve indefinitely. No counter logic is present.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum (IDLE, WAIT);
  - owner enum (OWN_IF, OWN_D);
  - counter width constant $clog2(4)+1.
- One sub-module, arb_starve_ctr, holds the saturating starve counter and the forced-fetch output. It is instantiated only under MEM_ARB_STARVE_GUARD_EN.

## Test plan
- Single fetch read, MEM_LAT=1:
  - Stimulus: if_req=1, if_addr=0x10 in cycle 0; mem_rdata=0x00500093 in cycle 1.
  - Response: if_gnt=1 and mem_addr=0x10 in cycle 0; busy=1 in cycle 1; if_rvalid=1 with if_rdata=0x00500093 in cycle 2.
- Simultaneous requests in IDLE:
  - Stimulus: if_req=1 and d_req=1, d_we=0, d_addr=0x200.
  - Response: d_gnt=1, if_gnt=0, mem_addr=0x200. Fetch is granted in the d_rvalid cycle.
- Back-to-back writes:
  - Stimulus: three d writes (0x100/0xA, 0x104/0xB, 0x108/0xC).
  - Response: d_gnt high for 3 consecutive cycles, busy stays 0, d_rvalid never pulses.
- MEM_LAT=3 read:
  - Stimulus: read granted in cycle 0.
  - Response: busy=1 in cycles 1–3; rvalid in cycle 4; no gnt in cycles 1–3 despite if_req=1.
- Reset mid-read:
  - Stimulus: rst=0 in cycle 1 of MEM_LAT=2, released in cycle 3.
  - Response: all outputs 0 immediately; no rvalid afterwards.
- Starvation guard (MEM_ARB_STARVE_GUARD_EN, STARVE_MAX=4):
  - Stimulus: d_req held high with writes and if_req high.
  - Response: the 5th arbitration cycle grants fetch. Without the macro, fetch is never granted.
